router_rx_port: RTL and testbench
=================================

ROUTER_RX_PORT -- requirements
Module: router_rx_port

Interface
REQ-001 Parameter: PORT_ID, 2'd0, destination address this port serves; header address compared against it.
REQ-002 Parameter: ABORT_CYCLES, 64, consecutive in-packet cycles without vld_out before the packet is abandoned.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 vld_out  input  1  router output FIFO non-empty.
REQ-006 data_out  input  8  router FIFO read data, valid the cycle after read_enb.
REQ-007 read_enb  output  1  FIFO read strobe, one byte per asserted cycle.
REQ-008 sink_ready  input  1  downstream may accept further bytes; gates reads only.
REQ-009 rx_data  output  8  payload byte to downstream.
REQ-010 rx_data_vld  output  1  rx_data valid this cycle; sink must accept.
REQ-011 rx_last  output  1  with rx_data_vld, marks final payload byte.
REQ-012 pkt_len  output  6  payload length from header, held until next header.
REQ-013 pkt_done  output  1  one-cycle pulse, packet fully consumed.
REQ-014 parity_err  output  1  valid with pkt_done; received parity mismatch.
REQ-015 addr_err  output  1  valid with pkt_done; header[1:0] != PORT_ID.
REQ-016 pkt_abort  output  1  one-cycle pulse, packet abandoned.

Function
REQ-017 Packet format: header (bits 7:2 length L, 1:0 address), L payload bytes, one parity byte = XOR of header and all payload bytes.
REQ-018 FSM states: IDLE, HDR, BODY, DRAIN, REPORT.
REQ-019 IDLE: read_enb = vld_out & sink_ready; on a read, go HDR.
REQ-020 HDR: read_enb = 0; capture data_out as header: pkt_len <= header[7:2], running parity <= header, issue counter <= L+1 (6-bit L, 7-bit counter); go BODY.
REQ-021 BODY: read_enb = vld_out & sink_ready & (counter != 0); each read decrements counter; on the read taking counter 1->0, go DRAIN.
REQ-022 Capture pipeline: a read issued in cycle N produces a captured byte in N+1; payload bytes XOR into running parity and appear on rx_data with rx_data_vld in N+1.
REQ-023 rx_last asserted with the L-th payload byte; never asserted when L = 0.
REQ-024 The final captured byte (parity) is not forwarded on rx_data; it is compared with running parity in DRAIN.
REQ-025 DRAIN: capture parity byte; go REPORT.
REQ-026 REPORT: pkt_done = 1, parity_err and addr_err valid; go IDLE next cycle; no read in REPORT.
REQ-027 L = 0: counter = 1; only parity read issued; no rx_data_vld for the packet.
REQ-028 Stall counter: in BODY, increments each cycle vld_out = 0, clears on any cycle vld_out = 1; reaching ABORT_CYCLES-1 -> pkt_abort pulse, return IDLE, no pkt_done, counters cleared.
REQ-029 sink_ready = 0 holds reads but does not advance the stall counter while vld_out = 1.
REQ-030 Bytes already read before sink_ready falls are still delivered (at most one, next cycle).
REQ-031 addr_err does not alter consumption; packet consumed fully regardless.
REQ-032 Back-to-back packets: next header read allowed in the IDLE cycle after REPORT.

Reset
REQ-033 On reset assertion, immediately: state IDLE, read_enb 0, rx_data 8'h00, rx_data_vld 0, rx_last 0, pkt_len 0, pkt_done 0, parity_err 0, addr_err 0, pkt_abort 0, counters and running parity 0.
REQ-034 Reset mid-packet discards the packet; no pkt_done or pkt_abort emitted; first read after release is treated as a header.

Verification
REQ-035 PORT_ID=1; FIFO holds 0x0D,0x11,0x22,0x33,parity 0x0D^0x11^0x22^0x33=0x0D, sink_ready=1 -> rx_data 11,22,33 with rx_last on 33, pkt_len 3, pkt_done with parity_err 0, addr_err 0; total 7 cycles IDLE read to pkt_done.
REQ-036 Same packet, parity byte 0x00 -> identical payload stream, pkt_done with parity_err 1.
REQ-037 Header 0x02 then parity 0x02 (PORT_ID=0, L=0... header 0x02 address 2) -> no rx_data_vld, pkt_done with addr_err 1, parity_err 0.
REQ-038 sink_ready low for 40 cycles mid-payload, vld_out high -> read_enb 0 for the stall, no pkt_abort, packet completes correctly after sink_ready returns.
REQ-039 vld_out low 64 consecutive cycles in BODY -> pkt_abort single pulse on 64th cycle, FSM IDLE, no pkt_done.
REQ-040 Reset asserted after second payload byte -> all outputs zero same cycle; fresh packet after release decodes correctly.

Source files
------------

// File: rtl/router_rx_port.sv
// Receive port for one router output channel.
// Reads packets (header, payload, parity) out of the router FIFO and streams
// the payload downstream. It reports each packet's length, parity status and
// address status. A packet whose FIFO stays empty too long is abandoned.
module router_rx_port #(
  parameter logic [1:0] PORT_ID      = 2'd0,
  parameter int         ABORT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  input  logic       sink_ready,
  output logic [7:0] rx_data,
  output logic       rx_data_vld,
  output logic       rx_last,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       pkt_abort
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    BODY   = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  // Stall counter trips when it is about to reach ABORT_CYCLES-1, so the
  // abort pulse lands on the ABORT_CYCLES-th empty cycle.
  localparam int STALL_W = (ABORT_CYCLES > 2) ? $clog2(ABORT_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_TRIP = STALL_W'(ABORT_CYCLES - 2);

  state_t             state;
  logic [6:0]         issue_cnt;   // reads still to issue: payload + parity
  logic [STALL_W-1:0] stall_cnt;
  logic [7:0]         parity_q;
  logic               addr_bad;
  logic               vld_p1;      // a payload byte arrives on data_out this cycle
  logic               last_p1;     // that byte is the final payload byte

  // FIFO read strobe: only IDLE (header) and BODY (payload/parity) issue reads.
  always_comb begin
    read_enb = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    read_enb = vld_out & sink_ready;
        BODY:    read_enb = vld_out & sink_ready & (issue_cnt != 7'd0);
        default: read_enb = 1'b0;
      endcase
    end
  end

  // Payload bytes go straight from the FIFO read port to the sink the cycle after the read.
  always_comb begin
    rx_data_vld = vld_p1;
    rx_last     = vld_p1 & last_p1;
    rx_data     = vld_p1 ? data_out : 8'h00;
  end

  // Packet FSM with the capture pipeline, parity accumulation and status reporting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      issue_cnt  <= 7'd0;
      stall_cnt  <= '0;
      parity_q   <= 8'h00;
      addr_bad   <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      pkt_len    <= 6'd0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;

      // capture stage: fold the arriving payload byte into the running parity
      if (vld_p1) begin
        parity_q <= parity_q ^ data_out;
      end

      case (state)
        IDLE: begin
          if (read_enb) begin
            state <= HDR;
          end
        end

        HDR: begin
          pkt_len   <= data_out[7:2];
          parity_q  <= data_out;
          issue_cnt <= {1'b0, data_out[7:2]} + 7'd1;
          addr_bad  <= (data_out[1:0] != PORT_ID);
          stall_cnt <= '0;
          state     <= BODY;
        end

        BODY: begin
          if (read_enb) begin
            issue_cnt <= issue_cnt - 7'd1;
            if (issue_cnt == 7'd1) begin
              state <= DRAIN;
            end else begin
              vld_p1  <= 1'b1;
              last_p1 <= (issue_cnt == 7'd2);
            end
          end
          if (vld_out) begin
            stall_cnt <= '0;
          end else if (stall_cnt == STALL_TRIP) begin
            pkt_abort <= 1'b1;
            stall_cnt <= '0;
            issue_cnt <= 7'd0;
            parity_q  <= 8'h00;
            state     <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end

        DRAIN: begin
          parity_err <= (data_out != parity_q);
          addr_err   <= addr_bad;
          pkt_done   <= 1'b1;
          state      <= REPORT;
        end

        REPORT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_rx_port.sv
// Bench for router_rx_port: behavioural FIFO feeding the port, with
// scoreboard queues of expected payload bytes and packet reports.
module tb_router_rx_port;

  localparam logic [1:0] PID   = 2'd1;
  localparam int         ABORT = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vld_out = 1'b0;
  logic       sink_ready = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       read_enb;
  logic [7:0] rx_data;
  logic       rx_data_vld;
  logic       rx_last;
  logic [5:0] pkt_len;
  logic       pkt_done;
  logic       parity_err;
  logic       addr_err;
  logic       pkt_abort;

  router_rx_port #(.PORT_ID(PID), .ABORT_CYCLES(ABORT)) dut (
    .clock       (clock),
    .reset       (reset),
    .vld_out     (vld_out),
    .data_out    (data_out),
    .read_enb    (read_enb),
    .sink_ready  (sink_ready),
    .rx_data     (rx_data),
    .rx_data_vld (rx_data_vld),
    .rx_last     (rx_last),
    .pkt_len     (pkt_len),
    .pkt_done    (pkt_done),
    .parity_err  (parity_err),
    .addr_err    (addr_err),
    .pkt_abort   (pkt_abort)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } pay_t;

  typedef struct packed {
    logic [5:0] len;
    logic       perr;
    logic       aerr;
  } done_t;

  logic [7:0] fifo[$];
  logic [7:0] pl_buf[$];
  pay_t       exp_pay[$];
  done_t      exp_done[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cycle = -1;
  int abort_count = 0;
  int abort_cycle = -1;
  int rx_count = 0;

  logic       vld_gate = 1'b1;
  logic       sink_gate = 1'b1;
  logic [7:0] next_data = 8'h00;
  logic       rd_now = 1'b0;

  // One clock of the FIFO model: present last read's byte, drive flags, pop on read.
  task automatic cycle();
    @(negedge clock);
    cyc++;
    data_out   = next_data;
    vld_out    = (fifo.size() != 0) && vld_gate;
    sink_ready = sink_gate;
    #1;
    rd_now = read_enb;
    if (read_enb && fifo.size() != 0) next_data = fifo.pop_front();
    #2;
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input bit corrupt, input logic [7:0] bad_par);
    logic [7:0] par;
    int         len;
    pay_t       p;
    done_t      d;
    len = int'(hdr[7:2]);
    par = hdr;
    fifo.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      fifo.push_back(pl_buf[i]);
      par    = par ^ pl_buf[i];
      p.data = pl_buf[i];
      p.last = (i == len - 1);
      exp_pay.push_back(p);
    end
    d.len  = hdr[7:2];
    d.aerr = (hdr[1:0] != PID);
    d.perr = corrupt && (bad_par != par);
    fifo.push_back(corrupt ? bad_par : par);
    exp_done.push_back(d);
  endtask

  task automatic fill_random(input int len);
    pl_buf.delete();
    for (int i = 0; i < len; i++) pl_buf.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (done_count == start) begin
      errors++;
      $display("FAIL %s_timeout: pkt_done count %0d, required %0d within %0d cycles", tag, done_count, start + 1, budget);
    end
  endtask

  // Scoreboard monitor, sampling mid-way through the low clock phase.
  always begin
    pay_t  p;
    done_t d;
    @(negedge clock);
    #2;
    if (rx_data_vld) begin
      rx_count++;
      checks++;
      if (exp_pay.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got data %02h last %b, required no byte", rx_data, rx_last);
      end else begin
        p = exp_pay.pop_front();
        if ({rx_data, rx_last} !== {p.data, p.last}) begin
          errors++;
          $display("FAIL rx_byte: got %02h last %b, required %02h last %b", rx_data, rx_last, p.data, p.last);
        end
      end
    end else if (!reset) begin
      checks++;
      if (rx_last !== 1'b0) begin
        errors++;
        $display("FAIL rx_last_idle: got %b, required 0", rx_last);
      end
    end
    if (pkt_done) begin
      done_count++;
      done_cycle = cyc;
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got pkt_done at cycle %0d, required none", cyc);
      end else begin
        d = exp_done.pop_front();
        if ({pkt_len, parity_err, addr_err} !== {d.len, d.perr, d.aerr}) begin
          errors++;
          $display("FAIL done_status: got len %0d perr %b aerr %b, required len %0d perr %b aerr %b",
                   pkt_len, parity_err, addr_err, d.len, d.perr, d.aerr);
        end
      end
    end
    if (pkt_abort) begin
      abort_count++;
      abort_cycle = cyc;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({read_enb, rx_data, rx_data_vld, rx_last, pkt_len, pkt_done, parity_err, addr_err, pkt_abort} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got re %b rx %02h vld %b last %b len %0d done %b perr %b aerr %b abort %b, required all 0",
               read_enb, rx_data, rx_data_vld, rx_last, pkt_len, pkt_done, parity_err, addr_err, pkt_abort);
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    int t0;
    int n;
    pl_buf = '{8'h11, 8'h22, 8'h33};
    push_pkt(8'h0D, 1'b0, 8'h00);
    t0 = -1;
    n = 0;
    while (t0 < 0 && n < 10) begin
      cycle();
      if (rd_now) t0 = cyc;
      n++;
    end
    wait_done("basic", 40);
    checks++;
    if (done_cycle - t0 !== 7) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles read to pkt_done, required 7", done_cycle - t0);
    end
    cycle();
    checks++;
    if (pkt_len !== 6'd3 || pkt_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got len %0d done %b, required len 3 done 0", pkt_len, pkt_done);
    end
  endtask

  task automatic test_parity_err();
    pl_buf = '{8'h11, 8'h22, 8'h33};
    push_pkt(8'h0D, 1'b1, 8'h00);
    wait_done("parity_err", 40);
    checks++;
    if (exp_pay.size() !== 0) begin
      errors++;
      $display("FAIL parity_err_stream: got %0d bytes undelivered, required 0", exp_pay.size());
    end
  endtask

  task automatic test_addr_zero_len();
    int rx0;
    rx0 = rx_count;
    pl_buf.delete();
    push_pkt(8'h02, 1'b0, 8'h00);
    wait_done("addr_zero_len", 30);
    checks++;
    if (rx_count !== rx0) begin
      errors++;
      $display("FAIL zero_len_rx: got %0d payload bytes, required 0", rx_count - rx0);
    end
  endtask

  task automatic test_sink_stall();
    int rx0;
    int reads;
    int ab0;
    int n;
    ab0 = abort_count;
    fill_random(5);
    push_pkt({6'd5, PID}, 1'b0, 8'h00);
    rx0 = rx_count;
    n = 0;
    while (rx_count < rx0 + 2 && n < 30) begin
      cycle();
      n++;
    end
    sink_gate = 1'b0;
    reads = 0;
    rx0 = rx_count;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (rd_now) reads++;
    end
    checks++;
    if (reads !== 0 || abort_count !== ab0 || rx_count - rx0 > 1) begin
      errors++;
      $display("FAIL sink_stall: got reads %0d aborts %0d late bytes %0d, required reads 0 aborts 0 late bytes <=1",
               reads, abort_count - ab0, rx_count - rx0);
    end
    sink_gate = 1'b1;
    wait_done("sink_stall", 40);
    checks++;
    if (exp_pay.size() !== 0) begin
      errors++;
      $display("FAIL sink_stall_stream: got %0d bytes undelivered, required 0", exp_pay.size());
    end
  endtask

  task automatic test_abort();
    int t0;
    int n;
    int ab0;
    int dn0;
    ab0 = abort_count;
    dn0 = done_count;
    fifo.push_back({6'd4, PID});
    t0 = -1;
    n = 0;
    while (t0 < 0 && n < 10) begin
      cycle();
      if (rd_now) t0 = cyc;
      n++;
    end
    repeat (75) cycle();
    checks++;
    if (abort_count - ab0 !== 1 || abort_cycle !== t0 + ABORT + 1 || done_count !== dn0) begin
      errors++;
      $display("FAIL abort_pulse: got %0d pulses at cycle offset %0d dones %0d, required 1 pulse at offset %0d dones 0",
               abort_count - ab0, abort_cycle - t0, done_count - dn0, ABORT + 1);
    end
    fill_random(2);
    push_pkt({6'd2, PID}, 1'b0, 8'h00);
    wait_done("after_abort", 30);
  endtask

  task automatic test_reset_mid();
    int rx0;
    int n;
    int dn0;
    int ab0;
    fill_random(4);
    push_pkt({6'd4, PID}, 1'b0, 8'h00);
    rx0 = rx_count;
    n = 0;
    while (rx_count < rx0 + 2 && n < 30) begin
      cycle();
      n++;
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({read_enb, rx_data, rx_data_vld, rx_last, pkt_len, pkt_done, parity_err, addr_err, pkt_abort} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got re %b rx %02h vld %b last %b len %0d done %b perr %b aerr %b abort %b, required all 0",
               read_enb, rx_data, rx_data_vld, rx_last, pkt_len, pkt_done, parity_err, addr_err, pkt_abort);
    end
    fifo.delete();
    exp_pay.delete();
    exp_done.delete();
    next_data = 8'h00;
    dn0 = done_count;
    ab0 = abort_count;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if (done_count !== dn0 || abort_count !== ab0) begin
      errors++;
      $display("FAIL reset_mid_pulses: got dones %0d aborts %0d, required 0 and 0", done_count - dn0, abort_count - ab0);
    end
    pl_buf = '{8'hA5, 8'h5A, 8'hC3};
    push_pkt({6'd3, PID}, 1'b0, 8'h00);
    wait_done("reset_mid_fresh", 30);
  endtask

  task automatic test_back_to_back();
    fill_random(2);
    push_pkt({6'd2, PID}, 1'b0, 8'h00);
    fill_random(1);
    push_pkt({6'd1, 2'd3}, 1'b1, 8'hFF);
    wait_done("b2b_first", 30);
    cycle();
    checks++;
    if (rd_now !== 1'b1 || cyc !== done_cycle + 1) begin
      errors++;
      $display("FAIL b2b_header_read: got read_enb %b at done+%0d, required 1 at done+1", rd_now, cyc - done_cycle);
    end
    wait_done("b2b_second", 30);
  endtask

  task automatic test_random();
    int target;
    int n;
    int ab0;
    ab0 = abort_count;
    target = done_count + 5;
    for (int k = 0; k < 5; k++) begin
      fill_random($urandom_range(0, 12));
      push_pkt({6'(pl_buf.size()), 2'($urandom_range(0, 3))}, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
    end
    n = 0;
    while (done_count < target && n < 3000) begin
      vld_gate  = ($urandom_range(0, 3) != 0);
      sink_gate = ($urandom_range(0, 4) != 0);
      cycle();
      n++;
    end
    vld_gate  = 1'b1;
    sink_gate = 1'b1;
    repeat (3) cycle();
    checks++;
    if (done_count !== target || exp_pay.size() !== 0 || abort_count !== ab0) begin
      errors++;
      $display("FAIL random_traffic: got dones %0d left bytes %0d aborts %0d, required dones %0d left 0 aborts 0",
               done_count, exp_pay.size(), abort_count - ab0, target);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_addr_zero_len();
    test_sink_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
